clk_div_ctrl: RTL

Run-time controller for the board clock divider. It produces a programmable divided clock and an aligned single-cycle tick from `clk_50`, starts and stops the output without runt pulses, and takes new divide ratios over a valid/ready handshake. New ratios take effect only at period boundaries. It sits between the 50 MHz board clock and the logic blocks that consume a slow clock or enable, and replaces the fixed-ratio divider wherever software or a top-level FSM must change the rate.

---
 rtl/clk_div_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: divided clock plus an aligned rising-edge tick from clk_50.
// clk_out/tick registered, rising one edge after enable is seen in OFF; new ratios apply only on rising edges.
// Single-entry config slot: cfg_ready drops while a ratio is pending, further offers are ignored.
module clk_div_ctrl #(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] active_div
);

    typedef enum logic [1:0] {OFF, RUN, STOP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_act_q, div_act_d;
    logic [DIV_W-1:0]   pend_div_q, pend_div_d;
    logic               pend_vld_q, pend_vld_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               tc;
    logic               apply;

    assign tc = (cnt_q == div_act_q - DIV_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        apply      = 1'b0;

        case (state_q)
            OFF: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                apply     = pend_vld_q;
                if (enable) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN, STOP: begin
                // Re-enabling during STOP behaves exactly like RUN, so the waveform is seamless.
                if (state_q == RUN && !enable) state_d = STOP;
                if (state_q == STOP && enable) state_d = RUN;
                if (tc) begin
                    cnt_d = '0;
                    apply = !clk_out_q && pend_vld_q;
                    if (clk_out_q) begin
                        clk_out_d = 1'b0;
                    end else if (state_q == RUN || enable) begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d = OFF;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = OFF;
        endcase

        if (apply) begin
            div_act_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end
        // Accept and apply are mutually exclusive: apply needs a pending ratio, accept needs none.
        if (cfg_valid && !pend_vld_q) begin
            pend_div_d = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            div_act_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign cfg_ready  = !pend_vld_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign busy       = (state_q != OFF);
    assign active_div = div_act_q;

endmodule
